// File: rtl/mailbox_ahb_slave_if.sv
// AHB-Lite signal bundle between a bus master and the test mailbox responder.
interface mailbox_ahb_slave_if;
  logic        hsel;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic [31:0] hrdata;
  logic [1:0]  hresp;

  modport master (
    output hsel, htrans, haddr, hwrite, hsize, hwdata, hready,
    input  hreadyout, hrdata, hresp
  );

  modport slave (
    input  hsel, htrans, haddr, hwrite, hsize, hwdata, hready,
    output hreadyout, hrdata, hresp
  );
endinterface

// File: rtl/mailbox_ahb_slave.sv
// AHB-Lite test mailbox: console byte FIFO, pass/fail marker decode, GPR dump registers.
module mailbox_ahb_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h2000_7C00,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                      sysclk,
  input  logic                      sysrst_b,
  mailbox_ahb_slave_if.slave        ahb,
  output logic                      char_vld,
  output logic [7:0]                char_data,
  input  logic                      char_rdy,
  output logic                      test_pass,
  output logic                      test_fail,
  output logic                      gpr_done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [7:0] OFF_CONSOLE = 8'h50;
  localparam logic [7:0] OFF_GPR_LO  = 8'h60;
  localparam logic [7:0] OFF_GPR_HI  = 8'h9C;
  localparam logic [7:0] OFF_STATUS  = 8'hA0;

  typedef enum logic [2:0] {IDLE, DATA, WAIT, ERR1, ERR2} state_t;

  state_t          state_q, state_d;
  logic [7:0]      off_q;
  logic            write_q;
  logic [31:0]     gpr [16];
  logic            pass_mark, fail_mark;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  logic accept, addr_err, fifo_full, is_marker, console_wr, gpr_sel;
  logic push, pop, data_done, resp_err;
  logic [3:0]  gpr_idx;
  logic [7:0]  a_off;
  logic [31:0] status;
  logic        unused_htrans0;

  assign unused_htrans0 = ahb.htrans[0];

  // Address-phase decode; all error conditions are known before the data phase.
  assign accept = ahb.hsel & ahb.htrans[1] & ahb.hready;
  assign a_off  = ahb.haddr[7:0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    addr_err = 1'b0;
    if (ahb.haddr[31:8] != BASE_ADDR[31:8] || a_off[1:0] != 2'b00)
      addr_err = 1'b1;
    else if (a_off == OFF_CONSOLE)
      addr_err = 1'b0;
    else if (a_off >= OFF_GPR_LO && a_off <= OFF_GPR_HI)
      addr_err = (ahb.hsize != 3'd2);
    else if (a_off == OFF_STATUS)
      addr_err = ahb.hwrite;
    else
      addr_err = 1'b1;
  end

  // 0x60..0x9C maps off[5:2] = 8..15,0..7 onto GPR 0..15.
  assign gpr_idx    = off_q[5:2] + 4'd8;
  assign gpr_sel    = (off_q >= OFF_GPR_LO) && (off_q <= OFF_GPR_HI);
  assign is_marker  = (ahb.hwdata == 32'h0000_1001) || (ahb.hwdata == 32'h0000_2002);
  assign console_wr = write_q && (off_q == OFF_CONSOLE);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign char_vld   = (count != '0);
  assign char_data  = fifo_mem[rd_ptr];
  assign pop        = char_vld & char_rdy;
  assign status     = {16'b0, 8'(count), 3'b0, fail_mark, pass_mark, gpr_done, test_fail, test_pass};

  always_ff @(posedge sysclk or negedge sysrst_b) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!sysrst_b) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    ahb.hreadyout = 1'b1;
    resp_err      = 1'b0;
    push          = 1'b0;
    data_done     = 1'b0;
    unique case (state_q)
      IDLE: state_d = accept ? (addr_err ? ERR1 : DATA) : IDLE;
      DATA: begin
        if (console_wr && !is_marker && fifo_full) begin
          ahb.hreadyout = 1'b0;
          state_d       = WAIT;
        end else begin
          data_done = 1'b1;
          push      = console_wr && !is_marker;
          state_d   = accept ? (addr_err ? ERR1 : DATA) : IDLE;
        end
      end
      WAIT: begin
        if (!fifo_full) begin
          push    = 1'b1;
          state_d = accept ? (addr_err ? ERR1 : DATA) : IDLE;
        end else begin
          ahb.hreadyout = 1'b0;
        end
      end
      ERR1: begin
        ahb.hreadyout = 1'b0;
        resp_err      = 1'b1;
        state_d       = ERR2;
      end
      ERR2: begin
        resp_err = 1'b1;
        state_d  = accept ? (addr_err ? ERR1 : DATA) : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ahb.hresp = {1'b0, resp_err};

  always_comb begin
    ahb.hrdata = '0;
    if (state_q == DATA && !write_q) begin
      if (gpr_sel)                   ahb.hrdata = gpr[gpr_idx];
      else if (off_q == OFF_STATUS)  ahb.hrdata = status;
    end
  end

  always_ff @(posedge sysclk or negedge sysrst_b) begin
    if (!sysrst_b) begin
      off_q   <= '0;
      write_q <= 1'b0;
    end else if (accept) begin
      off_q   <= a_off;
      write_q <= ahb.hwrite;
    end
  end

  always_ff @(posedge sysclk or negedge sysrst_b) begin
    if (!sysrst_b) begin
      pass_mark <= 1'b0;
      fail_mark <= 1'b0;
      test_pass <= 1'b0;
      test_fail <= 1'b0;
      gpr_done  <= 1'b0;
      for (int i = 0; i < 16; i++) gpr[i] <= '0;
    end else if (data_done && write_q) begin
      if (off_q == OFF_CONSOLE && ahb.hwdata == 32'h0000_1001) begin
        if (!fail_mark) fail_mark <= 1'b1;
        else            test_fail <= 1'b1;
      end
      if (off_q == OFF_CONSOLE && ahb.hwdata == 32'h0000_2002) begin
        if (!pass_mark) pass_mark <= 1'b1;
        else            test_pass <= 1'b1;
      end
      if (gpr_sel) begin
        gpr[gpr_idx] <= ahb.hwdata;
        if (off_q == OFF_GPR_HI) gpr_done <= 1'b1;
      end
    end
  end

  // Full test uses the registered count, so a same-cycle pop does not release a stalled push.
  always_ff @(posedge sysclk or negedge sysrst_b) begin
    if (!sysrst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: FIFO storage is not reset; only pointers and count qualify its contents.
  always_ff @(posedge sysclk) begin
    if (push) fifo_mem[wr_ptr] <= ahb.hwdata[7:0];
  end
endmodule
